vram_line_fetcher: RTL and testbench
====================================

Name: vram_line_fetcher

Overview:
- Downstream consumer of the video RAM's read port. On each scanline start, it streams a programmable run of words out of VRAM into a small prefetch FIFO.
- The FIFO output feeds the pixel serializer through a valid/ready interface.
- VRAM port B has a fixed 1-cycle registered read latency and no read enable. The fetcher owns the address and tracks which returning data are valid.

Parameters:
- ADDR_W, 14, VRAM word-address width (matches VRAM widthad).
- DATA_W, 32, VRAM word width.
- FIFO_DEPTH, 8, prefetch FIFO entries; must be a power of two, >= 2.
- H_WORDS, 80, words fetched per scanline; 1 <= H_WORDS <= 2**ADDR_W.

Ports:
- clock  in  1  sole clock; VRAM port B is clocked by the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse: begin fetching a new line.
- line_base  in  ADDR_W  first word address of the line; sampled on line_start.
- vram_addr  out  ADDR_W  VRAM port B address.
- vram_q  in  DATA_W  VRAM port B read data; holds mem[vram_addr] from the previous cycle.
- pix_data  out  DATA_W  FIFO head word.
- pix_valid  out  1  pix_data holds a valid word.
- pix_ready  in  1  consumer accepts the head; a pop occurs when pix_valid && pix_ready.
- busy  out  1  high outside IDLE.
- line_done  out  1  one-cycle pulse when the line has been fully fetched and drained.
- underrun  out  1  one-cycle pulse when pix_ready is high, pix_valid is low, and the state is FETCH or DRAIN.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - vram_addr=0, pix_data=0, pix_valid=0, busy=0, line_done=0, underrun=0.
  - FIFO empty; issue counter=0; in-flight flag=0.
- States:
  - IDLE: line_start -> FETCH. Load vram_addr=line_base and issue counter=0, flush the FIFO, clear the in-flight flag.
  - FETCH: issue one read per cycle while credit is available. Credit = (fifo_count + inflight + 1 <= FIFO_DEPTH).
    - Issue: vram_addr is presented this cycle and the in-flight flag is set for the next cycle.
    - After an issue, vram_addr increments modulo 2**ADDR_W. Wrap from all-ones to 0 is legal and silent. Issue counter increments.
    - When the issue counter reaches H_WORDS, stop issuing and go to DRAIN.
  - DRAIN: no issues. Once the in-flight flag is clear and the FIFO is empty -> IDLE, with line_done=1 for one cycle in the cycle IDLE is entered.
- Capture: when the in-flight flag is set, vram_q is written into the FIFO that cycle (same cycle vram_q becomes valid). Latency from the first issue to pix_valid is 2 cycles.
- No-credit cycles: vram_addr holds. The in-flight flag clears with no capture.
- FIFO:
  - Simultaneous push and pop allowed; count unchanged.
  - Push when full is impossible by the credit rule. Verification asserts it never occurs.
  - Pop when empty is ignored, and the underrun rule applies.
- pix_data / pix_valid: show the FIFO head combinationally from registered storage. pix_data is don't-care while pix_valid=0 (hold last value acceptable).
- line_start outside IDLE (mid-line restart):
  - Abort the current line: flush the FIFO and drop any in-flight word (the next cycle's vram_q is discarded).
  - Reload from line_base; state=FETCH; no line_done for the aborted line.
- line_start coincident with a pop: the pop is ignored (flush wins).
- line_start coincident with the DRAIN->IDLE transition: the restart wins and line_done is suppressed.
- underrun: never asserted in IDLE. It does not alter state or counts.
- Sustained throughput with pix_ready held high: 1 word/cycle after the 2-cycle start latency. The credit rule allows continuous issue once steady state is reached, because pop frees a slot in the same cycle.

Test Plan:
- Reset while busy (assert reset_n=0 mid-FETCH):
  - All outputs go to 0 immediately, asynchronously.
  - After release, state is IDLE and no line_done pulse occurs.
- Basic line (H_WORDS=80, line_base=0x0100, VRAM preloaded mem[a]=a, pix_ready=1):
  - pix_valid rises 2 cycles after line_start.
  - Words 0x0100..0x014F are delivered on 80 consecutive cycles.
  - line_done is a single pulse, one cycle after the last pop.
- Backpressure (pix_ready=0 for 20 cycles after line_start):
  - Exactly FIFO_DEPTH=8 issues occur, then vram_addr holds at 0x0108.
  - On ready: words are delivered in order with no loss or duplicates, and no underrun.
- Wrap (ADDR_W=14, line_base=0x3FFE, H_WORDS=4):
  - Delivered addresses are 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Mid-line restart (line_start with line_base=0x0200 at word 10 of a 0x0100 line, with one read in flight):
  - No 0x010A/0x010B data appears after the restart.
  - The next valid word is 0x0200, and the first line produces no line_done.
- Underrun (pix_ready=1 asserted on the line_start cycle):
  - underrun pulses in the first FETCH cycle and the one after (FIFO still empty).
  - No underrun occurs once pix_valid is high.
  - No underrun occurs in IDLE even when pix_ready=1.

Source files
------------

// File: rtl/vram_line_fetcher.sv
// Scanline prefetcher: streams H_WORDS consecutive VRAM words (1-cycle read latency)
// into a small FIFO that feeds the pixel serializer over valid/ready.
//
// state | meaning
// IDLE  | waiting for line_start; FIFO empty
// FETCH | issuing one read per cycle while FIFO credit allows
// DRAIN | all reads issued; waiting for the last capture and the FIFO to empty
module vram_line_fetcher #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int H_WORDS    = 80
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_base,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [DATA_W-1:0] vram_q,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              line_done,
    output logic              underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ISS_W = $clog2(H_WORDS + 1);
    localparam logic [CNT_W-1:0] FULL_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ISS_W-1:0] LAST_ISS  = ISS_W'(H_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ISS_W-1:0]  iss_q, iss_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              line_done_q, line_done_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              credit;
    logic [CNT_W:0]    occupancy;

    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign vram_addr = addr_q;
    assign busy      = (state_q != IDLE);
    assign line_done = line_done_q;
    assign underrun  = pix_ready && !pix_valid && (state_q == FETCH || state_q == DRAIN);

    // A word already in flight will occupy a slot next cycle, so it counts against credit.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign credit    = (occupancy < DEPTH_C);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        iss_d       = iss_q;
        inflight_d  = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        line_done_d = 1'b0;
        push        = inflight_q;
        pop         = pix_valid && pix_ready;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            IDLE: ;
            FETCH: begin
                if (credit) begin
                    inflight_d = 1'b1;
                    addr_d     = addr_q + ADDR_W'(1);
                    iss_d      = iss_q + ISS_W'(1);
                    if (iss_q == LAST_ISS) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave on the cycle of the final pop so line_done follows it directly.
                if (!inflight_q && count_d == '0) begin
                    state_d     = IDLE;
                    line_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new line overrides everything, including a pending capture, pop or completion.
        if (line_start) begin
            state_d     = FETCH;
            addr_d      = line_base;
            iss_d       = '0;
            inflight_d  = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            line_done_d = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            iss_q       <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            iss_q       <= iss_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            line_done_q <= line_done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= vram_q;
        end
    end

    full_push_a: assert property (@(posedge clock) disable iff (!reset_n) !(push && count_q == FULL_C));

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Scoreboard bench for vram_line_fetcher: expected words are queued by the stimulus
// and popped by per-instance monitors whenever a pix_valid && pix_ready handshake occurs.
module tb_vram_line_fetcher;

    localparam int AW = 14;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // main instance (H_WORDS=80)
    logic          line_start, pix_ready, pix_valid, busy, line_done, underrun;
    logic [AW-1:0] line_base, vram_addr;
    logic [DW-1:0] vram_q, pix_data;

    // short-line instance (H_WORDS=4) for address wrap
    logic          line_start_w, pix_ready_w, pix_valid_w, busy_w, line_done_w, underrun_w;
    logic [AW-1:0] line_base_w, vram_addr_w;
    logic [DW-1:0] vram_q_w, pix_data_w;

    vram_line_fetcher #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8), .H_WORDS(80)) dut (
        .clock(clock), .reset_n(reset_n), .line_start(line_start), .line_base(line_base),
        .vram_addr(vram_addr), .vram_q(vram_q), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .line_done(line_done), .underrun(underrun)
    );

    vram_line_fetcher #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8), .H_WORDS(4)) dut_w (
        .clock(clock), .reset_n(reset_n), .line_start(line_start_w), .line_base(line_base_w),
        .vram_addr(vram_addr_w), .vram_q(vram_q_w), .pix_data(pix_data_w), .pix_valid(pix_valid_w),
        .pix_ready(pix_ready_w), .busy(busy_w), .line_done(line_done_w), .underrun(underrun_w)
    );

    // VRAM preloaded with mem[a] = a, 1-cycle registered read
    always_ff @(posedge clock) begin
        vram_q   <= DW'(vram_addr);
        vram_q_w <= DW'(vram_addr_w);
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w[$];
    int cyc = 0;
    int pops = 0, first_pop = -1, last_pop = 0, un_cnt = 0, ld_cnt = 0, ld_cyc = 0;
    int pops_w = 0, ld_cnt_w = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=0x%0h required=no_word", pix_data);
                end else begin
                    check("pix_data", pix_data, exp_q.pop_front());
                end
                pops++;
                last_pop = cyc;
                if (first_pop < 0) first_pop = cyc;
            end
            if (underrun) un_cnt++;
            if (line_done) begin
                ld_cnt++;
                ld_cyc = cyc;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            if (pix_valid_w && pix_ready_w) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected_w actual=0x%0h required=no_word", pix_data_w);
                end else begin
                    check("pix_data_w", pix_data_w, exp_w.pop_front());
                end
                pops_w++;
            end
            if (line_done_w) ld_cnt_w++;
        end
    end

    task automatic start_line(input logic [AW-1:0] base);
        @(posedge clock);
        #1;
        line_start = 1'b1;
        line_base  = base;
        @(posedge clock);
        #1;
        line_start = 1'b0;
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(DW'(first + i));
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 400; i++) begin
            if (ld_cnt >= target) break;
            @(posedge clock);
        end
        check(name, ld_cnt, target);
    endtask

    int un0, pops0, ld0;

    initial begin
        line_start = 0; line_base = '0; pix_ready = 0;
        line_start_w = 0; line_base_w = '0; pix_ready_w = 0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // reset state and IDLE behaviour
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_line_done", line_done, 0);
        pix_ready = 1'b1;
        @(negedge clock);
        check("idle_underrun", underrun, 0);

        // reset asserted mid-FETCH
        push_range(32'h100, 80);
        start_line(14'h0100);
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_addr", vram_addr, 0);
        check("arst_valid", pix_valid, 0);
        check("arst_data", pix_data, 0);
        check("arst_busy", busy, 0);
        check("arst_underrun", underrun, 0);
        check("arst_line_done", line_done, 0);
        exp_q.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("post_rst_busy", busy, 0);
        check("post_rst_no_done", ld_cnt, 0);

        // basic line with pix_ready held high; also the underrun window
        un0 = un_cnt; pops0 = pops; first_pop = -1;
        push_range(32'h100, 80);
        start_line(14'h0100);
        @(negedge clock);
        check("underrun_fetch1", underrun, 1);
        check("valid_fetch1", pix_valid, 0);
        check("busy_fetch1", busy, 1);
        @(negedge clock);
        check("underrun_fetch2", underrun, 1);
        check("valid_fetch2", pix_valid, 0);
        @(negedge clock);
        check("valid_latency", pix_valid, 1);
        check("underrun_with_valid", underrun, 0);
        wait_done(1, "basic_done");
        check("basic_pops", pops - pops0, 80);
        check("basic_consecutive", last_pop - first_pop, 79);
        check("basic_done_timing", ld_cyc, last_pop + 1);
        check("basic_queue_empty", exp_q.size(), 0);
        repeat (5) @(negedge clock);
        check("basic_underruns", un_cnt - un0, 2);
        check("basic_single_done", ld_cnt, 1);
        check("basic_idle", busy, 0);

        // backpressure: consumer stalls 20 cycles
        @(posedge clock);
        #1 pix_ready = 1'b0;
        un0 = un_cnt; pops0 = pops;
        push_range(32'h100, 80);
        start_line(14'h0100);
        repeat (10) @(negedge clock);
        check("bp_addr_hold_a", vram_addr, 14'h0108);
        check("bp_valid", pix_valid, 1);
        repeat (9) @(negedge clock);
        check("bp_addr_hold_b", vram_addr, 14'h0108);
        @(posedge clock);
        #1 pix_ready = 1'b1;
        wait_done(2, "bp_done");
        check("bp_pops", pops - pops0, 80);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_no_underrun", un_cnt - un0, 0);

        // mid-line restart with 0x010A in flight
        ld0 = ld_cnt; pops0 = pops;
        push_range(32'h100, 9);
        start_line(14'h0100);
        repeat (11) @(posedge clock);
        #1;
        pix_ready  = 1'b0;
        line_start = 1'b1;
        line_base  = 14'h0200;
        check("restart_pre_queue", exp_q.size(), 0);
        push_range(32'h200, 80);
        @(posedge clock);
        #1;
        line_start = 1'b0;
        pix_ready  = 1'b1;
        wait_done(ld0 + 1, "restart_done");
        repeat (5) @(negedge clock);
        check("restart_single_done", ld_cnt, ld0 + 1);
        check("restart_queue_empty", exp_q.size(), 0);
        check("restart_pops", pops - pops0, 89);

        // address wrap on the short-line instance
        pix_ready_w = 1'b1;
        exp_w.push_back(32'h3FFE);
        exp_w.push_back(32'h3FFF);
        exp_w.push_back(32'h0000);
        exp_w.push_back(32'h0001);
        @(posedge clock);
        #1;
        line_start_w = 1'b1;
        line_base_w  = 14'h3FFE;
        @(posedge clock);
        #1 line_start_w = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ld_cnt_w >= 1) break;
            @(posedge clock);
        end
        check("wrap_done", ld_cnt_w, 1);
        check("wrap_pops", pops_w, 4);
        check("wrap_queue_empty", exp_w.size(), 0);
        check("wrap_addr", vram_addr_w, 14'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
